// File: rtl/temppid_mc.sv
// temppid_mc: time-multiplexed multi-channel PID for VDC temperature servos.
// Ports: clk, rst_n (async, active low); start strobes one servo tick.
// Per-channel inputs: on, is_neg, s_in, kp_sh/ki_sh/kd_sh and errmult, all latched at start.
// LL/UL are shared signed output limits. NH holds all duty words and is refreshed as one set.
// valid pulses with each NH refresh, busy marks a running sequence, and overrun is sticky.
module temppid_mc #(
  parameter int NCH = 4,
  parameter int IO_W = 18,
  parameter int FB = 16,
  parameter int MULT_W = 7,
  parameter int ACC_W = IO_W + FB + 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NCH-1:0]           on,
  input  logic [NCH-1:0]           is_neg,
  input  logic [NCH*IO_W-1:0]      s_in,
  input  logic [NCH*5-1:0]         kp_sh,
  input  logic [NCH*5-1:0]         ki_sh,
  input  logic [NCH*5-1:0]         kd_sh,
  input  logic [NCH*MULT_W-1:0]    errmult,
  input  logic signed [IO_W-1:0]   LL,
  input  logic signed [IO_W-1:0]   UL,
  output logic [NCH*IO_W-1:0]      NH,
  output logic                     valid,
  output logic                     busy,
  output logic                     overrun
);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int PW = ACC_W + MULT_W;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (FB - 1);
  typedef enum logic [2:0] {IDLE, TERM, SUM, MUL, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] c;
  logic [NCH*IO_W-1:0] s_r;
  logic [NCH-1:0] on_r, neg_r;
  logic [NCH*5-1:0] kp_r, ki_r, kd_r;
  logic [NCH*MULT_W-1:0] em_r;
  logic signed [ACC_W-1:0] i_acc [NCH];
  logic signed [ACC_W-1:0] e_prev [NCH];
  logic signed [IO_W-1:0] shadow [NCH];
  logic signed [ACC_W-1:0] p_r, i_r, d_r, sum_r;
  logic signed [IO_W-1:0] s_c, nh_c, out_c;
  logic signed [MULT_W-1:0] em_c;
  logic [4:0] kp_c, ki_c, kd_c;
  logic signed [ACC_W-1:0] e, p, d, i_add, i_new, sum, ll_w, ul_w;
  logic signed [PW-1:0] prod;
  logic inh;
  // Channel datapath; LL/UL are live, everything else comes from the latched set.
  always_comb begin
    s_c = s_r[c*IO_W +: IO_W];
    nh_c = NH[c*IO_W +: IO_W];
    em_c = em_r[c*MULT_W +: MULT_W];
    kp_c = kp_r[c*5 +: 5];
    ki_c = ki_r[c*5 +: 5];
    kd_c = kd_r[c*5 +: 5];
    e = neg_r[c] ? -ACC_W'(s_c) : ACC_W'(s_c);
    ll_w = ACC_W'(LL) <<< FB;
    ul_w = ACC_W'(UL) <<< FB;
    p = (e <<< FB) >>> kp_c;
    d = ((e - e_prev[c]) <<< FB) >>> kd_c;
    // Anti-windup: stop integrating further into a limit the output already sits on.
    inh = (nh_c == UL && e > 0) || (nh_c == LL && e < 0);
    i_add = inh ? i_acc[c] : i_acc[c] + ((e <<< FB) >>> ki_c);
    i_new = i_add > ul_w ? ul_w : i_add < ll_w ? ll_w : i_add;
    sum = p_r + i_r + d_r + HALF;
    prod = (PW'(sum_r >>> FB) * PW'(em_c)) >>> 4;
    out_c = prod > PW'(UL) ? UL : prod < PW'(LL) ? LL : prod[IO_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = start ? TERM : IDLE;
      TERM: state_nx = SUM;
      SUM: state_nx = MUL;
      MUL: state_nx = c == CW'(NCH - 1) ? DONE : TERM;
      default: state_nx = IDLE;
    endcase
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= '0;
      s_r <= '0;
      on_r <= '0;
      neg_r <= '0;
      kp_r <= '0;
      ki_r <= '0;
      kd_r <= '0;
      em_r <= '0;
      p_r <= '0;
      i_r <= '0;
      d_r <= '0;
      sum_r <= '0;
      NH <= '0;
      valid <= 1'b0;
      overrun <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        i_acc[k] <= '0;
        e_prev[k] <= '0;
        shadow[k] <= '0;
      end
    end else begin
      valid <= state == DONE;
      if (start && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: if (start) begin
          s_r <= s_in;
          on_r <= on;
          neg_r <= is_neg;
          kp_r <= kp_sh;
          ki_r <= ki_sh;
          kd_r <= kd_sh;
          em_r <= errmult;
          c <= '0;
        end
        TERM: begin
          i_acc[c] <= on_r[c] ? i_new : '0;
          e_prev[c] <= on_r[c] ? e : '0;
          p_r <= p;
          i_r <= i_new;
          d_r <= d;
        end
        SUM: sum_r <= sum;
        MUL: begin
          shadow[c] <= on_r[c] ? out_c : '0;
          if (c != CW'(NCH - 1)) c <= c + 1'b1;
        end
        default: for (int k = 0; k < NCH; k++) NH[k*IO_W +: IO_W] <= shadow[k];
      endcase
    end
  end
endmodule

// File: tb/tb_temppid_mc.sv
// tb_temppid_mc: scoreboard bench for temppid_mc with a behavioural PID reference model.
module tb_temppid_mc;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] on_v = 4'hf, neg_v = 4'h0;
  longint s[4], em[4], ll, ul;
  int kp[4], ki[4], kd[4];
  logic [71:0] s_in, nh;
  logic [19:0] kp_sh, ki_sh, kd_sh;
  logic [27:0] errmult;
  logic signed [17:0] ll_s, ul_s;
  logic valid, busy, overrun;
  longint mi[4], mep[4], mnh[4];
  longint exp_q[$];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      s_in[c*18 +: 18] = s[c][17:0];
      kp_sh[c*5 +: 5] = kp[c][4:0];
      ki_sh[c*5 +: 5] = ki[c][4:0];
      kd_sh[c*5 +: 5] = kd[c][4:0];
      errmult[c*7 +: 7] = em[c][6:0];
    end
    ll_s = ll[17:0];
    ul_s = ul[17:0];
  end
  temppid_mc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .on(on_v), .is_neg(neg_v), .s_in(s_in),
    .kp_sh(kp_sh), .ki_sh(ki_sh), .kd_sh(kd_sh), .errmult(errmult), .LL(ll_s), .UL(ul_s),
    .NH(nh), .valid(valid), .busy(busy), .overrun(overrun)
  );
  task automatic chk(input string tag, input longint got, input longint want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, want);
  endtask
  function automatic longint nh_of(input int c);
    logic signed [17:0] w;
    w = nh[c*18 +: 18];
    return longint'(w);
  endfunction
  // Reference model for one servo tick; pushes the expected NH set.
  task automatic model_tick();
    longint res[4];
    for (int c = 0; c < 4; c++) begin
      longint e, p, d, ia, si, pr;
      e = neg_v[c] ? -s[c] : s[c];
      if (!on_v[c]) begin
        mi[c] = 0;
        mep[c] = 0;
        res[c] = 0;
      end else begin
        p = (e <<< 16) >>> kp[c];
        d = ((e - mep[c]) <<< 16) >>> kd[c];
        ia = ((mnh[c] == ul && e > 0) || (mnh[c] == ll && e < 0)) ? mi[c] : mi[c] + ((e <<< 16) >>> ki[c]);
        ia = ia > (ul <<< 16) ? (ul <<< 16) : ia < (ll <<< 16) ? (ll <<< 16) : ia;
        mi[c] = ia;
        mep[c] = e;
        si = (p + ia + d + 32768) >>> 16;
        pr = (si * em[c]) >>> 4;
        res[c] = pr > ul ? ul : pr < ll ? ll : pr;
      end
    end
    for (int c = 0; c < 4; c++) begin
      mnh[c] = res[c];
      exp_q.push_back(res[c]);
    end
  endtask
  task automatic tick(input bit poke);
    int n;
    @(negedge clk);
    start = 1'b1;
    model_tick();
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_hi", busy, 1);
    n = 0;
    while (!valid && n < 40) begin
      @(posedge clk);
      #1 n++;
      start = poke && n == 3;
    end
    start = 1'b0;
    chk("latency", n, 13);
    chk("busy_lo", busy, 0);
    for (int c = 0; c < 4; c++) chk($sformatf("nh%0d", c), nh_of(c), exp_q.pop_front());
    @(posedge clk);
    #1 chk("valid_pulse", valid, 0);
  endtask
  initial begin
    int seen;
    for (int c = 0; c < 4; c++) begin
      s[c] = 0;
      em[c] = 16;
      kp[c] = 31;
      ki[c] = 31;
      kd[c] = 31;
      mi[c] = 0;
      mep[c] = 0;
      mnh[c] = 0;
    end
    ll = 0;
    ul = 100000;
    #12;
    for (int c = 0; c < 4; c++) chk($sformatf("rst_nh%0d", c), nh_of(c), 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_valid", valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_nh0", nh_of(0), 0);
    kp[0] = 0;
    s[0] = 100;
    tick(0);
    chk("p_only", nh_of(0), 100);
    ki[1] = 0;
    s[1] = 10;
    for (int i = 1; i <= 3; i++) begin
      tick(0);
      chk("integ", nh_of(1), 10 * i);
    end
    ki[2] = 0;
    s[2] = 60000;
    tick(0);
    chk("aw_1", nh_of(2), 60000);
    tick(0);
    chk("aw_clamp", nh_of(2), 100000);
    s[2] = -10000;
    tick(0);
    chk("aw_release", nh_of(2), 90000);
    s[0] = 1001;
    em[0] = 8;
    tick(0);
    chk("mult_half", nh_of(0), 500);
    kp[3] = 0;
    s[3] = 100;
    neg_v[3] = 1'b1;
    tick(0);
    chk("neg_ll", nh_of(3), 0);
    ll = -500;
    em[0] = -16;
    s[0] = 1000;
    tick(0);
    chk("mult_neg", nh_of(0), -500);
    ll = 0;
    em[0] = 16;
    chk("ovr_pre", overrun, 0);
    tick(1);
    chk("ovr_set", overrun, 1);
    tick(0);
    chk("ovr_sticky", overrun, 1);
    neg_v[3] = 1'b0;
    kp[3] = 31;
    ki[3] = 0;
    s[3] = 50;
    on_v[3] = 1'b0;
    tick(0);
    chk("off_nh3", nh_of(3), 0);
    on_v[3] = 1'b1;
    tick(0);
    chk("reen_1", nh_of(3), 50);
    tick(0);
    chk("reen_2", nh_of(3), 100);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ovr", overrun, 0);
    for (int c = 0; c < 4; c++) chk($sformatf("arst_nh%0d", c), nh_of(c), 0);
    for (int c = 0; c < 4; c++) begin
      mi[c] = 0;
      mep[c] = 0;
      mnh[c] = 0;
    end
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 seen |= int'(valid);
    end
    chk("arst_no_valid", seen, 0);
    tick(0);
    chk("post_rst", nh_of(3), 50);
    chk("q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
